// File: rtl/tpu_pkg.sv
// Shared types for the activation stage: activation modes, FSM states and default width.
package tpu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ACT_PASS  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLIP  = 2'd3
    } act_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } act_state_e;

endpackage

// File: rtl/activation_unit_if.sv
// Output beat stream of the activation unit: LANES elements per beat under valid/ready.
interface act_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] Out [LANES];

    modport master (output out_valid, output out_last, output Out, input out_ready);
    modport slave  (input out_valid, input out_last, input Out, output out_ready);
endinterface

// File: rtl/act_lane.sv
// Combinational single-element activation: pass, ReLU, leaky ReLU (arithmetic shift), clipped ReLU.
module act_lane
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SHIFT_W    = 4
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  act_mode_e                    mode,
    input  logic        [SHIFT_W-1:0]    leak_shift,
    input  logic signed [DATA_WIDTH-1:0] clip_max,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         neg
);
    assign neg = x[DATA_WIDTH-1];

    always_comb begin
        y = x;
        case (mode)
            ACT_PASS:  y = x;
            ACT_RELU:  y = neg ? '0 : x;
            ACT_LEAKY: y = neg ? (x >>> leak_shift) : x;
            ACT_CLIP: begin
                // A negative ceiling would otherwise leak through as a negative output
                if (neg || clip_max[DATA_WIDTH-1]) y = '0;
                else if (x > clip_max)            y = clip_max;
                else                              y = x;
            end
            default:   y = x;
        endcase
    end
endmodule

// File: rtl/activation_unit.sv
// Vector activation stage: captures a LENGTH-element vector on start, streams activated
// beats of LANES elements under valid/ready, and counts negative inputs per vector.
module activation_unit
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LENGTH     = 64,
    parameter int LANES      = 8,
    parameter int SHIFT_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [SHIFT_W-1:0]            leak_shift,
    input  logic [DATA_WIDTH-1:0]         clip_max,
    input  logic [DATA_WIDTH-1:0]         In [LENGTH],
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(LENGTH+1)-1:0]   neg_count,
    act_if.master                         ob
);
    localparam int NBEATS = LENGTH / LANES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int CNT_W  = $clog2(LENGTH + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    act_state_e            state_reg, state_next;
    logic [BEAT_W-1:0]     beat_reg;
    logic                  load_beat;
    logic                  capture;
    logic [CNT_W-1:0]      beat_negs;

    act_mode_e             mode_reg;
    logic [SHIFT_W-1:0]    shift_reg;
    logic [DATA_WIDTH-1:0] clip_reg;
    logic [DATA_WIDTH-1:0] buf_reg [NBEATS][LANES];

    logic [DATA_WIDTH-1:0] lane_y [LANES];
    logic [LANES-1:0]      lane_neg;

    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign capture = (state_reg == ST_IDLE) && start;

    always_comb begin
        state_next = state_reg;
        load_beat  = 1'b0;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_LOAD;
            ST_LOAD: begin
                load_beat  = 1'b1;
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (ob.out_valid && ob.out_ready) begin
                    if (ob.out_last) state_next = ST_DONE;
                    else             load_beat  = 1'b1;
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        beat_negs = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_negs = beat_negs + CNT_W'(lane_neg[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            beat_reg     <= '0;
            neg_count    <= '0;
            ob.out_valid <= 1'b0;
            ob.out_last  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                ob.Out[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (capture) begin
                beat_reg  <= '0;
                neg_count <= '0;
            end
            if (load_beat) begin
                for (int i = 0; i < LANES; i++) begin
                    ob.Out[i] <= lane_y[i];
                end
                ob.out_valid <= 1'b1;
                ob.out_last  <= (beat_reg == LAST_BEAT);
                beat_reg     <= beat_reg + 1'b1;
                neg_count    <= neg_count + beat_negs;
            end else if (state_reg == ST_STREAM && ob.out_valid && ob.out_ready && ob.out_last) begin
                ob.out_valid <= 1'b0;
                ob.out_last  <= 1'b0;
            end
        end
    end

    // Capture storage carries no reset; it is only read after a capture has filled it
    always_ff @(posedge clk) begin
        if (capture) begin
            mode_reg  <= act_mode_e'(mode);
            shift_reg <= leak_shift;
            clip_reg  <= clip_max;
            for (int i = 0; i < LENGTH; i++) begin
                buf_reg[i / LANES][i % LANES] <= In[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            act_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .SHIFT_W    (SHIFT_W)
            ) u_lane (
                .x          ($signed(buf_reg[beat_reg][gi])),
                .mode       (mode_reg),
                .leak_shift (shift_reg),
                .clip_max   ($signed(clip_reg)),
                .y          (lane_y[gi]),
                .neg        (lane_neg[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit: directed vectors plus randomized runs against a behavioural model.
module tb_activation_unit;
    import tpu_pkg::*;

    localparam int DW   = 16;
    localparam int LEN  = 8;
    localparam int LN   = 4;
    localparam int SW   = 4;
    localparam int NB   = LEN / LN;
    localparam int CW   = $clog2(LEN + 1);
    localparam int NONE = 100000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [SW-1:0] leak_shift = '0;
    logic [DW-1:0] clip_max = '0;
    logic [DW-1:0] In [LEN];
    logic          busy;
    logic          done;
    logic [CW-1:0] neg_count;

    act_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

    activation_unit #(
        .DATA_WIDTH (DW),
        .LENGTH     (LEN),
        .LANES      (LN),
        .SHIFT_W    (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .leak_shift (leak_shift),
        .clip_max   (clip_max),
        .In         (In),
        .busy       (busy),
        .done       (done),
        .neg_count  (neg_count),
        .ob         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int got_q[$];
    int exp_neg = 0;
    int beats_seen = 0;
    int done_count = 0;
    bit rand_ready = 1'b0;
    bit ready_force = 1'b1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    // Reference activation from plain arithmetic: leaky = floor(x / 2^shift)
    function automatic int model(input int x, input int m, input int sh, input int clip);
        int d, q;
        case (m)
            0: return x;
            1: return (x < 0) ? 0 : x;
            2: begin
                if (x >= 0) return x;
                d = 1 << sh;
                q = x / d;
                if (q * d != x) q = q - 1;
                return q;
            end
            default: begin
                if (x < 0 || clip < 0) return 0;
                return (x > clip) ? clip : x;
            end
        endcase
    endfunction

    function automatic int rnd_elem();
        case ($urandom_range(0, 5))
            0: return -32768;
            1: return 32767;
            2: return -1;
            3: return 0;
            default: return sx(DW'($urandom));
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_force;
    end

    // Compare process: every accepted beat, hold-stability, done pulse and neg_count
    logic [DW-1:0] prev_out [LN];
    bit prev_stall = 1'b0;
    bit last_acc = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                for (int i = 0; i < LN; i++) chk("hold_stable", sx(bus.Out[i]), sx(prev_out[i]));
            end
            if (last_acc) chk("done_after_last", done, 1);
            if (bus.out_valid && bus.out_ready) begin
                beats_seen++;
                for (int i = 0; i < LN; i++) begin
                    int e;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : NONE;
                    chk("beat_data", sx(bus.Out[i]), e);
                    got_q.push_back(sx(bus.Out[i]));
                end
                chk("out_last", bus.out_last, int'(beats_seen == NB));
                $display("beat %0d: %0d %0d %0d %0d last=%0d", beats_seen, sx(bus.Out[0]), sx(bus.Out[1]),
                         sx(bus.Out[2]), sx(bus.Out[3]), bus.out_last);
            end
            if (done) begin
                chk("neg_count", int'(neg_count), exp_neg);
                chk("beats_per_vector", beats_seen, NB);
                chk("busy_in_done", busy, 1);
                done_count++;
            end
            last_acc   = bus.out_valid && bus.out_ready && bus.out_last;
            prev_stall = bus.out_valid && !bus.out_ready;
            for (int i = 0; i < LN; i++) prev_out[i] = bus.Out[i];
        end else begin
            prev_stall = 1'b0;
            last_acc   = 1'b0;
        end
    end

    task automatic launch(input int m, input int sh, input int clip, input int vals[LEN], input bit expect_accept);
        for (int i = 0; i < LEN; i++) In[i] = DW'(vals[i]);
        mode       = 2'(m);
        leak_shift = SW'(sh);
        clip_max   = DW'(clip);
        if (expect_accept) begin
            exp_neg    = 0;
            beats_seen = 0;
            got_q.delete();
            for (int i = 0; i < LEN; i++) begin
                exp_q.push_back(model(sx(DW'(vals[i])), m, sh, sx(DW'(clip))));
                if (sx(DW'(vals[i])) < 0) exp_neg++;
            end
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_count < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_count < target) begin
            errors++;
            $display("FAIL done_timeout actual=%0d required=%0d", done_count, target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_literal(input string name, input int lit[LEN]);
        for (int i = 0; i < LEN; i++) begin
            chk(name, (i < got_q.size()) ? got_q[i] : NONE, lit[i]);
        end
    endtask

    int v[LEN];
    int lit[LEN];
    int n;
    int dc;

    initial begin
        for (int i = 0; i < LEN; i++) In[i] = '0;
        bus.out_ready = 1'b1;

        // Model pinned against hand-computed values
        chk("model_leaky_m5", model(-5, 2, 2, 0), -2);
        chk("model_leaky_max_shift", model(-1, 2, 15, 0), -1);
        chk("model_clip_neg_ceiling", model(5, 3, 0, -1), 0);
        chk("model_clip_top", model(32767, 3, 0, 1536), 1536);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_neg_count", int'(neg_count), 0);
        for (int i = 0; i < LN; i++) chk("rst_out", sx(bus.Out[i]), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: ReLU, ready held high, first-valid latency and literal results
        ready_force = 1'b1;
        v = '{5, -3, 0, 32767, -32768, 100, -1, 7};
        launch(1, 0, 0, v, 1'b1);
        chk("busy_after_start", busy, 1);
        chk("valid_in_load", bus.out_valid, 0);
        @(posedge clk);
        #1 chk("first_valid", bus.out_valid, 1);
        wait_done(1);
        lit = '{5, 0, 0, 32767, 0, 100, 0, 7};
        check_literal("s1_relu_lit", lit);
        chk("s1_neg_lit", int'(neg_count), 3);
        chk("busy_after_done", busy, 0);

        // 2: leaky, shift 2
        v = '{-8, -1, 12, -32768, 4, -5, 0, 1};
        launch(2, 2, 0, v, 1'b1);
        wait_done(2);
        lit = '{-2, -1, 12, -8192, 4, -2, 0, 1};
        check_literal("s2_leaky_lit", lit);

        // 3: clipped, then negative ceiling
        v = '{'h0700, 'h0600, 'h05FF, -1, 32767, 0, 1, -32768};
        launch(3, 0, 'h0600, v, 1'b1);
        wait_done(3);
        lit = '{'h0600, 'h0600, 'h05FF, 0, 'h0600, 0, 1, 0};
        check_literal("s3_clip_lit", lit);
        launch(3, 0, -1, v, 1'b1);
        wait_done(4);
        lit = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_literal("s3_clip_neg_lit", lit);

        // 4: backpressure for 5 cycles after first valid
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < LEN; i++) v[i] = rnd_elem();
        launch(0, 0, 0, v, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("s4_valid_seen", bus.out_valid, 1);
        repeat (5) @(posedge clk);
        #1 chk("s4_no_accept_while_stalled", beats_seen, 0);
        ready_force = 1'b1;
        wait_done(5);
        chk("s4_total_beats", beats_seen, NB);

        // 5: pass mode with an ignored start during streaming
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < LEN; i++) v[i] = rnd_elem();
        v[0] = -7;
        launch(0, 0, 0, v, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < LEN; i++) lit[i] = -100 - i;
        launch(1, 0, 0, lit, 1'b0);
        ready_force = 1'b1;
        wait_done(6);
        repeat (10) @(posedge clk);
        #1 chk("s5_single_done", done_count, 6);
        chk("s5_first_elem_pass", got_q[0], -7);

        // 6: asynchronous reset after beat0 accepted
        ready_force = 1'b1;
        for (int i = 0; i < LEN; i++) v[i] = rnd_elem();
        launch(2, 3, 0, v, 1'b1);
        n = 0;
        while (beats_seen < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s6_beat0_seen", beats_seen, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("s6_valid_low", bus.out_valid, 0);
        chk("s6_busy_low", busy, 0);
        chk("s6_done_low", done, 0);
        chk("s6_neg_count_zero", int'(neg_count), 0);
        exp_q.delete();
        dc = done_count;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 chk("s6_no_done", done_count, dc);
        for (int i = 0; i < LEN; i++) v[i] = rnd_elem();
        launch(1, 0, 0, v, 1'b1);
        wait_done(dc + 1);

        // Randomized vectors with random backpressure
        rand_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < LEN; i++) v[i] = rnd_elem();
            launch(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), rnd_elem(), v, 1'b1);
            wait_done(dc + 2 + t);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        chk("rand_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
